// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory port arbiter: address width
// derivation and packed-port slice indexing.
package mem_arb_pkg;

  localparam int NREQ_MAX = 8;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Low bit of element idx in a packed vector of elements w bits wide.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority selector: first eligible requester at or above rr_ptr,
// wrapping around, as a one-hot grant plus its binary index.
module rr_priority_select #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ <= 1) ? 1 : $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx
);

  always_comb begin
    logic            found;
    logic [IDXW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDXW'((int'(rr_ptr) + k) % NREQ);
      if (!found && eligible[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one async-read memory port between NREQ
// requesters, with a registered read-response slot per requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int NREQ  = 2,
  parameter int AW    = addr_width(DEPTH),
  parameter int IDXW  = (NREQ <= 1) ? 1 : $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*WIDTH-1:0] resp_rdata,
  output logic [AW-1:0]         MEM_RADDR,
  input  logic [WIDTH-1:0]      MEM_RDATA,
  output logic [AW-1:0]         MEM_WADDR,
  output logic [WIDTH-1:0]      MEM_WDATA,
  output logic                  MEM_WEN
);

  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [NREQ*WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            accept;
  logic            accept_we;
  logic [AW-1:0]   grant_addr;

  // Writes bypass the response slot; reset gating keeps the memory quiet while held.
  assign eligible = req_valid & (req_we | ~resp_valid_q | resp_ready)
                  & {NREQ{ASYNCRESETN}};

  rr_priority_select #(.NREQ(NREQ), .IDXW(IDXW)) u_select (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    accept     = |grant;
    accept_we  = accept && req_we[grant_idx];
    grant_addr = req_addr[slice_lo(int'(grant_idx), AW) +: AW];
    MEM_RADDR  = accept ? grant_addr : '0;
    MEM_WADDR  = accept ? grant_addr : '0;
    MEM_WEN    = accept_we;
    MEM_WDATA  = accept_we ? req_wdata[slice_lo(int'(grant_idx), WIDTH) +: WIDTH] : '0;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      if (!accept_we) begin
        resp_valid_d[grant_idx] = 1'b1;
        resp_rdata_d[slice_lo(int'(grant_idx), WIDTH) +: WIDTH] = MEM_RDATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural async-read memory
// initialised to addr0=5, addr1=0, addr2=21, addr3=11.
module tb_mem_port_arbiter;

  localparam int WIDTH = 5;
  localparam int AW    = 2;
  localparam int NREQ  = 2;

  logic                  CLK;
  logic                  ASYNCRESETN;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [NREQ*WIDTH-1:0] resp_rdata;
  logic [AW-1:0]         MEM_RADDR;
  logic [WIDTH-1:0]      MEM_RDATA;
  logic [AW-1:0]         MEM_WADDR;
  logic [WIDTH-1:0]      MEM_WDATA;
  logic                  MEM_WEN;

  logic [WIDTH-1:0] mem [4];
  logic             mem_load;

  int total;
  int bad;

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(4), .NREQ(NREQ)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .MEM_RADDR   (MEM_RADDR),
    .MEM_RDATA   (MEM_RDATA),
    .MEM_WADDR   (MEM_WADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_WEN     (MEM_WEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: async read, write at the rising edge, bulk init on load.
  assign MEM_RDATA = mem[MEM_RADDR];
  always @(posedge CLK) begin
    if (mem_load) begin
      mem[0] <= 5'd5;
      mem[1] <= 5'd0;
      mem[2] <= 5'd21;
      mem[3] <= 5'd11;
    end else if (MEM_WEN) begin
      mem[MEM_WADDR] <= MEM_WDATA;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] we,
                       input logic [1:0] a0, input logic [1:0] a1,
                       input logic [4:0] d0, input logic [4:0] d1,
                       input logic [1:0] rready);
    req_valid  = valid;
    req_we     = we;
    req_addr   = {a1, a0};
    req_wdata  = {d1, d0};
    resp_ready = rready;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    mem_load    = 1'b0;
    drive(2'b00, 2'b00, 2'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    settle();
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_resp_valid got=%b exp=00", resp_valid); end
    total++;
    if (resp_rdata !== 10'd0) begin bad++; $display("[TB] FAIL reset_resp_rdata got=%h exp=000", resp_rdata); end
    total++;
    if (MEM_WEN !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_wen got=%b exp=0", MEM_WEN); end
    tick();
    ASYNCRESETN = 1'b1;
    mem_load    = 1'b1;
    tick();
    mem_load    = 1'b0;
  endtask

  task automatic test_single_read();
    drive(2'b01, 2'b00, 2'd2, 2'd0, 5'd0, 5'd0, 2'b00);
    settle();
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_ready got=%b exp=01", req_ready); end
    total++;
    if (MEM_RADDR !== 2'd2) begin bad++; $display("[TB] FAIL single_raddr got=%0d exp=2", MEM_RADDR); end
    tick();
    req_valid = 2'b00;
    total++;
    if (resp_valid !== 2'b01) begin bad++; $display("[TB] FAIL single_resp_valid got=%b exp=01", resp_valid); end
    total++;
    if (resp_rdata[4:0] !== 5'd21) begin bad++; $display("[TB] FAIL single_rdata got=%0d exp=21", resp_rdata[4:0]); end
    resp_ready = 2'b01;
    tick();
    total++;
    if (resp_valid !== 2'b00) begin bad++; $display("[TB] FAIL single_consumed got=%b exp=00", resp_valid); end
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 2'b00, 2'd3, 2'd0, 5'd0, 5'd0, 2'b01);
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp=01", c, req_ready); end
      tick();
      total++;
      if (resp_valid !== 2'b01 || resp_rdata[4:0] !== 5'd11)
        begin bad++; $display("[TB] FAIL b2b_resp cyc=%0d got=%b/%0d exp=01/11", c, resp_valid, resp_rdata[4:0]); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b10;
    exp_grant[1] = 2'b01;
    exp_grant[2] = 2'b10;
    exp_grant[3] = 2'b01;
    drive(2'b11, 2'b00, 2'd0, 2'd3, 5'd0, 5'd0, 2'b11);
    for (int c = 0; c < 4; c++) begin
      settle();
      total++;
      if (req_ready !== exp_grant[c]) begin bad++; $display("[TB] FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_grant[c]); end
      tick();
      total++;
      if (resp_valid !== exp_grant[c]) begin bad++; $display("[TB] FAIL rr_resp_valid cyc=%0d got=%b exp=%b", c, resp_valid, exp_grant[c]); end
      total++;
      if (exp_grant[c] == 2'b01 ? (resp_rdata[4:0] !== 5'd5) : (resp_rdata[9:5] !== 5'd11))
        begin bad++; $display("[TB] FAIL rr_rdata cyc=%0d got=%h exp=%s", c, resp_rdata, exp_grant[c] == 2'b01 ? "r0=5" : "r1=11"); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_blocked_response();
    drive(2'b10, 2'b00, 2'd0, 2'd3, 5'd0, 5'd0, 2'b00);
    tick();
    total++;
    if (resp_valid !== 2'b10 || resp_rdata[9:5] !== 5'd11)
      begin bad++; $display("[TB] FAIL blk_setup got=%b/%0d exp=10/11", resp_valid, resp_rdata[9:5]); end
    drive(2'b11, 2'b00, 2'd0, 2'd2, 5'd0, 5'd0, 2'b01);
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL blk_ready cyc=%0d got=%b exp=01", c, req_ready); end
      tick();
      total++;
      if (resp_valid !== 2'b11 || resp_rdata[9:5] !== 5'd11)
        begin bad++; $display("[TB] FAIL blk_hold cyc=%0d got=%b/%0d exp=11/11", c, resp_valid, resp_rdata[9:5]); end
    end
    resp_ready = 2'b11;
    settle();
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL blk_release_ready got=%b exp=10", req_ready); end
    tick();
    total++;
    if (resp_valid !== 2'b10 || resp_rdata[9:5] !== 5'd21)
      begin bad++; $display("[TB] FAIL blk_refill got=%b/%0d exp=10/21", resp_valid, resp_rdata[9:5]); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_write_then_read();
    drive(2'b01, 2'b01, 2'd1, 2'd0, 5'd17, 5'd0, 2'b00);
    settle();
    total++;
    if (req_ready !== 2'b01 || MEM_WEN !== 1'b1 || MEM_WADDR !== 2'd1 || MEM_WDATA !== 5'd17)
      begin bad++; $display("[TB] FAIL wr_port got=%b/%b/%0d/%0d exp=01/1/1/17", req_ready, MEM_WEN, MEM_WADDR, MEM_WDATA); end
    tick();
    total++;
    if (resp_valid !== 2'b00 || resp_rdata[4:0] !== 5'd5)
      begin bad++; $display("[TB] FAIL wr_no_resp got=%b/%0d exp=00/5", resp_valid, resp_rdata[4:0]); end
    req_we = 2'b00;
    settle();
    total++;
    if (MEM_WEN !== 1'b0 || req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rd_after_wr_port got=%b/%b exp=0/01", MEM_WEN, req_ready); end
    tick();
    total++;
    if (resp_valid !== 2'b01 || resp_rdata[4:0] !== 5'd17)
      begin bad++; $display("[TB] FAIL rd_after_wr got=%b/%0d exp=01/17", resp_valid, resp_rdata[4:0]); end
    drive(2'b00, 2'b00, 2'd0, 2'd0, 5'd0, 5'd0, 2'b11);
    tick();
  endtask

  task automatic test_write_pending();
    drive(2'b10, 2'b00, 2'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(2'b10, 2'b10, 2'd0, 2'd2, 5'd0, 5'd9, 2'b00);
    settle();
    total++;
    if (req_ready !== 2'b10 || MEM_WEN !== 1'b1 || MEM_WADDR !== 2'd2 || MEM_WDATA !== 5'd9)
      begin bad++; $display("[TB] FAIL wp_port got=%b/%b/%0d/%0d exp=10/1/2/9", req_ready, MEM_WEN, MEM_WADDR, MEM_WDATA); end
    tick();
    total++;
    if (resp_valid !== 2'b10 || resp_rdata[9:5] !== 5'd5)
      begin bad++; $display("[TB] FAIL wp_resp_kept got=%b/%0d exp=10/5", resp_valid, resp_rdata[9:5]); end
    drive(2'b01, 2'b00, 2'd2, 2'd0, 5'd0, 5'd0, 2'b00);
    tick();
    total++;
    if (resp_valid !== 2'b11 || resp_rdata[4:0] !== 5'd9)
      begin bad++; $display("[TB] FAIL wp_readback got=%b/%0d exp=11/9", resp_valid, resp_rdata[4:0]); end
    req_valid = 2'b00;
  endtask

  task automatic test_async_reset();
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    total++;
    if (resp_valid !== 2'b00 || resp_rdata !== 10'd0)
      begin bad++; $display("[TB] FAIL arst_clear got=%b/%h exp=00/000", resp_valid, resp_rdata); end
    tick();
    ASYNCRESETN = 1'b1;
    tick();
    drive(2'b11, 2'b00, 2'd2, 2'd3, 5'd0, 5'd0, 2'b11);
    settle();
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL arst_first_grant got=%b exp=01", req_ready); end
    tick();
    total++;
    if (resp_valid !== 2'b01 || resp_rdata[4:0] !== 5'd9)
      begin bad++; $display("[TB] FAIL arst_mem_kept got=%b/%0d exp=01/9", resp_valid, resp_rdata[4:0]); end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_blocked_response();
    test_write_then_read();
    test_write_pending();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
